// File: rtl/axi_wr_pkg.sv
// axi_wr_pkg: shared record layout, FSM states and B-response codes for the AXI write path
// Transaction record (REC_W bits): [63:0] addr, [66:64] alen, [69:67] asize, [77:70] aid, rest unused.
package axi_wr_pkg;
    localparam int REC_W    = 97;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 63;
    localparam int LEN_LSB  = 64;
    localparam int LEN_MSB  = 66;
    localparam int SIZE_LSB = 67;
    localparam int SIZE_MSB = 69;
    localparam int ID_LSB   = 70;
    localparam int ID_MSB   = 77;
    typedef enum logic [1:0] {IDLE, LOAD, BURST} state_t;
    typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} bresp_t;
endpackage

// File: rtl/axi_wstrb_gen.sv
// axi_wstrb_gen: byte strobes for one beat from the beat address lane bits and asize
// Ports: lane_i (address bits below the bus width), asize_i (log2 bytes per beat)
//        -> wstrb_o (byte enables), size_err_o (beat wider than the bus).
module axi_wstrb_gen #(
    parameter int DATA_W = 64
) (
    input  logic [$clog2(DATA_W/8)-1:0] lane_i,
    input  logic [2:0]                  asize_i,
    output logic [DATA_W/8-1:0]         wstrb_o,
    output logic                        size_err_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    logic [7:0]        nbytes;
    logic [7:0]        nmask;
    logic [LANE_W-1:0] lane;
    // Unaligned addresses are rounded down to the beat size; an oversized beat enables every lane.
    always_comb begin
        nbytes     = 8'd1 << asize_i;
        nmask      = nbytes - 8'd1;
        size_err_o = int'(nbytes) > STRB_W;
        lane       = lane_i & ~nmask[LANE_W-1:0];
        wstrb_o    = '0;
        for (int i = 0; i < STRB_W; i++)
            wstrb_o[i] = size_err_o || (i >= int'(lane) && i < int'(lane) + int'(nbytes));
    end
endmodule

// File: rtl/axi_wdata_gen.sv
// axi_wdata_gen: streams write-data FIFO beats onto the AXI W channel, one burst per transaction record
// Ports: transaction FIFO (empty/rddata/rd), write-data FIFO (empty/rddata/rd), AXI W channel
//        (wid/wdata/wstrb/wlast/wvalid/wready), AXI B channel (bid/bresp/bvalid/bready),
//        status (err_valid/err_id pulse on error response, sticky proto_err, busy).
module axi_wdata_gen
    import axi_wr_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 8,
    parameter int CNT_W     = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                transfifo_empty_i,
    input  logic [REC_W-1:0]    transfifo_rddata_i,
    output logic                transfifo_rd_o,
    input  logic                wdata_fifo_empty_i,
    input  logic [DATA_W-1:0]   wdata_fifo_rddata_i,
    output logic                wdata_fifo_rd_o,
    output logic [7:0]          axi_wid_o,
    output logic [DATA_W-1:0]   axi_wdata_o,
    output logic [DATA_W/8-1:0] axi_wstrb_o,
    output logic                axi_wlast_o,
    output logic                axi_wvalid_o,
    input  logic                axi_wready_i,
    input  logic [7:0]          axi_bid_i,
    input  logic [1:0]          axi_bresp_i,
    input  logic                axi_bvalid_i,
    output logic                axi_bready_o,
    output logic                err_valid_o,
    output logic [7:0]          err_id_o,
    output logic                proto_err_o,
    output logic                busy_o
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    state_t             state_q;
    logic [7:0]         aid_q;
    logic [2:0]         asize_q;
    logic [2:0]         beat_cnt_q;
    logic [63:0]        addr_q;
    logic [CNT_W-1:0]   outst_q;
    logic [CNT_W-1:0]   outst_d;
    logic               err_valid_q;
    logic [7:0]         err_id_q;
    logic               proto_err_q;
    logic               in_burst;
    logic               hs;
    logic               last_hs;
    logic               b_hs;
    logic               b_err;
    logic               size_err;
    logic [STRB_W-1:0]  strb;

    axi_wstrb_gen #(.DATA_W(DATA_W)) u_strb (
        .lane_i     (addr_q[LANE_W-1:0]),
        .asize_i    (asize_q),
        .wstrb_o    (strb),
        .size_err_o (size_err)
    );

    assign in_burst        = state_q == BURST;
    // The outstanding check uses the registered count, so a B arriving in the stall cycle frees it one cycle later.
    assign transfifo_rd_o  = !reset_i && state_q == IDLE && !transfifo_empty_i && outst_q < CNT_W'(MAX_OUTST);
    assign axi_wvalid_o    = in_burst && !wdata_fifo_empty_i;
    assign axi_wlast_o     = axi_wvalid_o && beat_cnt_q == 3'd0;
    assign axi_wdata_o     = in_burst ? wdata_fifo_rddata_i : '0;
    assign axi_wstrb_o     = in_burst ? strb : '0;
    assign axi_wid_o       = aid_q;
    assign wdata_fifo_rd_o = axi_wvalid_o && axi_wready_i;
    assign axi_bready_o    = !reset_i;
    assign err_valid_o     = err_valid_q;
    assign err_id_o        = err_id_q;
    assign proto_err_o     = proto_err_q;
    assign busy_o          = state_q != IDLE || outst_q != '0;
    assign hs              = wdata_fifo_rd_o;
    assign last_hs         = axi_wlast_o && axi_wready_i;
    assign b_hs            = axi_bvalid_i && axi_bready_o;
    assign b_err           = b_hs && axi_bresp_i != OKAY;

    // A burst completing in the same cycle as a response leaves the count unchanged; decrement saturates at zero.
    always_comb begin
        outst_d = (last_hs && !b_hs) ? outst_q + CNT_W'(1) :
                  (b_hs && !last_hs && outst_q != '0) ? outst_q - CNT_W'(1) : outst_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            aid_q       <= '0;
            asize_q     <= '0;
            beat_cnt_q  <= '0;
            addr_q      <= '0;
            outst_q     <= '0;
            err_valid_q <= 1'b0;
            err_id_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (transfifo_rd_o) begin
                    aid_q      <= transfifo_rddata_i[ID_MSB:ID_LSB];
                    asize_q    <= transfifo_rddata_i[SIZE_MSB:SIZE_LSB];
                    beat_cnt_q <= transfifo_rddata_i[LEN_MSB:LEN_LSB];
                    addr_q     <= transfifo_rddata_i[ADDR_MSB:ADDR_LSB];
                    state_q    <= LOAD;
                end
                LOAD: begin
                    state_q <= BURST;
                    if (size_err) proto_err_q <= 1'b1;
                end
                BURST: if (hs) begin
                    beat_cnt_q <= beat_cnt_q - 3'd1;
                    addr_q     <= addr_q + (64'd1 << asize_q);
                    if (beat_cnt_q == 3'd0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            outst_q     <= outst_d;
            err_valid_q <= b_err;
            if (b_err) err_id_q <= axi_bid_i;
            if (b_hs && !last_hs && outst_q == '0) proto_err_q <= 1'b1;
        end
    end
endmodule
